// File: rtl/risc_pkg.sv
// Shared types and constants for the front-end pipeline.
//   INSTR_W, ADDR_W : instruction and address widths
//   NOP_INSTR       : instruction word presented when there is nothing to issue
//   fq_entry_t      : one fetch-queue entry {instr, pc_next}
package risc_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_next;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_store.sv
// Entry storage for the fetch/decode queue: DEPTH x fq_entry_t registers,
// one synchronous write port and one asynchronous read port. Storage is not
// reset; validity is tracked entirely by the owner's pointers and count.
//   clk     : rising-edge clock
//   wr_en   : write wr_data into entry wr_addr at the clock edge
//   wr_addr : write index
//   wr_data : entry to write
//   rd_addr : read index
//   rd_data : entry at rd_addr (combinational)
module fetch_queue_store
    import risc_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  fq_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output fq_entry_t        rd_data
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode. Captures cache-hit instructions
// with their sequential next-PC, presents them to decode under valid/ready,
// back-pressures fetch when full and discards everything on a taken branch.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue zero-latency path).
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   instr_in    : instruction from fetch
//   hit_in      : instr_in valid (cache hit) this cycle
//   pc_next_in  : sequential next address of instr_in
//   flush       : taken branch; kills queued and incoming entries
//   fetch_stall : queue full, fetch must hold PC
//   instr_out   : head instruction to decode
//   pc_next_out : head next-PC to decode
//   valid_out   : head entry valid
//   ready_in    : decode accepts head this cycle
//   count       : occupied entries
module fetch_decode_queue
    import risc_pkg::*;
#(
    parameter int INSTR_W = risc_pkg::INSTR_W,
    parameter int ADDR_W  = risc_pkg::ADDR_W,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INSTR_W-1:0]         instr_in,
    input  logic                       hit_in,
    input  logic [ADDR_W-1:0]          pc_next_in,
    input  logic                       flush,
    output logic                       fetch_stall,
    output logic [INSTR_W-1:0]         instr_out,
    output logic [ADDR_W-1:0]          pc_next_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             enq;
    logic             wr_en;
    logic             deq;
    logic             q_deq;
    fq_entry_t        wr_entry;
    fq_entry_t        head;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Bypass is gated by rst so reset forces the idle outputs even while
    // fetch keeps presenting hits.
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & hit_in & ~flush & ~rst;
`else
    assign bypass = 1'b0;
`endif

    assign enq   = hit_in & ~full & ~flush;
    assign deq   = valid_out & ready_in;
    // A bypassed entry taken by decode in the same cycle never enters storage.
    assign wr_en = enq & ~(bypass & ready_in);
    // Only handshakes on a stored head remove an entry from storage.
    assign q_deq = deq & ~empty;

    assign wr_entry.instr   = instr_in;
    assign wr_entry.pc_next = pc_next_in;

    fetch_queue_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // DEPTH is a power of two, so pointer increments wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (q_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(q_deq);
        end
    end

    // fetch_stall depends only on the registered count, so ready_in has no
    // combinational path to it.
    assign fetch_stall = full;

    always_comb begin
        instr_out   = NOP_INSTR;
        pc_next_out = '0;
        if (!empty) begin
            instr_out   = head.instr;
            pc_next_out = head.pc_next;
        end else if (bypass) begin
            instr_out   = instr_in;
            pc_next_out = pc_next_in;
        end
        valid_out = ~flush & (~empty | bypass);
    end

endmodule
